// File: rtl/regfile_writeback_queue_if.sv
// Write-back request, register-file write port, scoreboard and forwarding lookup bundle.
// slave = queue side, master = surrounding datapath/bench side.
interface regfile_writeback_queue_if #(
    parameter int N = 32
);
    logic         flush;
    logic         wb_valid;
    logic         wb_ready;
    logic [4:0]   wb_reg;
    logic [N-1:0] wb_data;
    logic         rf_grant;
    logic         rf_write;
    logic [4:0]   rf_write_reg;
    logic [N-1:0] rf_write_data;
    logic [31:0]  pending;
    logic         empty;
    logic         full;
    logic [4:0]   read_reg1;
    logic [4:0]   read_reg2;
    logic         fwd_hit1;
    logic         fwd_hit2;
    logic [N-1:0] fwd_data1;
    logic [N-1:0] fwd_data2;

    modport slave (
        input  flush, wb_valid, wb_reg, wb_data, rf_grant, read_reg1, read_reg2,
        output wb_ready, rf_write, rf_write_reg, rf_write_data, pending, empty, full,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    modport master (
        output flush, wb_valid, wb_reg, wb_data, rf_grant, read_reg1, read_reg2,
        input  wb_ready, rf_write, rf_write_reg, rf_write_data, pending, empty, full,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Purpose: FIFO of register write-backs draining into the register file, with pending-destination scoreboard.
// Latency: entry accepted at edge E drives rf_write from E, written at E+1 if granted; optional WB_FORWARD_EN lookup.
// Backpressure: wb_ready = !full from registered count only; drain stalls while rf_grant is low.
module regfile_writeback_queue #(
    parameter int n     = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    regfile_writeback_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       reg_q  [DEPTH];
    logic [4:0]       reg_d  [DEPTH];
    logic [n-1:0]     data_q [DEPTH];
    logic [n-1:0]     data_d [DEPTH];

    logic empty_s, full_s, push, pop;
    logic [31:0] pending_s;

    assign empty_s = (count_q == '0);
    assign full_s  = (count_q == (PW+1)'(DEPTH));
    assign push    = bus.wb_valid && !full_s && (bus.wb_reg != 5'd0) && !bus.flush;
    assign pop     = !empty_s && bus.rf_grant;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        reg_d    = reg_q;
        data_d   = data_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            valid_d  = '0;
        end else begin
            if (push) begin
                reg_d[wr_ptr_q]   = bus.wb_reg;
                data_d[wr_ptr_q]  = bus.wb_data;
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
        end
    end

    // x0 is never stored, so bit 0 of the scoreboard stays clear by construction.
    always_comb begin
        pending_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) pending_s[reg_q[i]] = 1'b1;
        end
    end

    assign bus.wb_ready      = !full_s;
    assign bus.empty         = empty_s;
    assign bus.full          = full_s;
    assign bus.pending       = pending_s;
    assign bus.rf_write      = pop;
    assign bus.rf_write_reg  = empty_s ? 5'd0 : reg_q[rd_ptr_q];
    assign bus.rf_write_data = empty_s ? '0   : data_q[rd_ptr_q];

`ifdef WB_FORWARD_EN
    logic [PW-1:0] fwd_idx;
    logic          hit1, hit2;
    logic [n-1:0]  fdat1, fdat2;

    // Walk oldest to youngest so the last match (youngest) is the one kept.
    always_comb begin
        hit1    = 1'b0;
        hit2    = 1'b0;
        fdat1   = '0;
        fdat2   = '0;
        fwd_idx = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + k[PW-1:0];
            if (valid_q[fwd_idx] && bus.read_reg1 != 5'd0 && reg_q[fwd_idx] == bus.read_reg1) begin
                hit1  = 1'b1;
                fdat1 = data_q[fwd_idx];
            end
            if (valid_q[fwd_idx] && bus.read_reg2 != 5'd0 && reg_q[fwd_idx] == bus.read_reg2) begin
                hit2  = 1'b1;
                fdat2 = data_q[fwd_idx];
            end
        end
    end

    assign bus.fwd_hit1  = hit1;
    assign bus.fwd_hit2  = hit2;
    assign bus.fwd_data1 = fdat1;
    assign bus.fwd_data2 = fdat2;
`else
    logic unused_read_regs;
    assign unused_read_regs = ^{bus.read_reg1, bus.read_reg2};
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: reset, drain, fill/stall, x0 drop, push+pop, flush, forwarding.
module tb_regfile_writeback_queue;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    regfile_writeback_queue_if #(.N(32)) bus ();

    regfile_writeback_queue #(.n(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_reg   = r;
        bus.wb_data  = d;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_reg    = '0;
        bus.wb_data   = '0;
        bus.rf_grant  = 1'b1;
        bus.read_reg1 = '0;
        bus.read_reg2 = '0;
        #12;
        chk("rst_empty",   bus.empty, 1);
        chk("rst_full",    bus.full, 0);
        chk("rst_ready",   bus.wb_ready, 1);
        chk("rst_pending", bus.pending, 0);
        chk("rst_write",   bus.rf_write, 0);
        chk("rst_wreg",    bus.rf_write_reg, 0);
        chk("rst_wdata",   bus.rf_write_data, 0);
        chk("rst_hit1",    bus.fwd_hit1, 0);
        rst = 1'b1;
        bus.rf_grant = 1'b0;
        tick();

        // Reset mid-fill
        push(5'd5, 32'hA);
        push(5'd6, 32'hB);
        chk("fill_pending", bus.pending, 64'h60);
        chk("fill_empty",   bus.empty, 0);
        bus.rf_grant = 1'b1;
        rst = 1'b0;
        #1;
        chk("midrst_empty",   bus.empty, 1);
        chk("midrst_pending", bus.pending, 0);
        chk("midrst_write",   bus.rf_write, 0);
        chk("midrst_ready",   bus.wb_ready, 1);
        #2;
        rst = 1'b1;
        tick();
        chk("postrst_write", bus.rf_write, 0);

        // Basic drain with grant held
        bus.rf_grant = 1'b1;
        push(5'd3, 32'h1234);
        chk("drain_write",   bus.rf_write, 1);
        chk("drain_reg",     bus.rf_write_reg, 3);
        chk("drain_data",    bus.rf_write_data, 32'h1234);
        chk("drain_pending", bus.pending, 64'h8);
        tick();
        chk("drain_empty", bus.empty, 1);
        chk("drain_idle",  bus.rf_write, 0);

        // Fill while stalled, then drain in order
        bus.rf_grant = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
        chk("full_full",    bus.full, 1);
        chk("full_ready",   bus.wb_ready, 0);
        chk("full_pending", bus.pending, 64'h1E);
        chk("full_nowrite", bus.rf_write, 0);
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd10;
        bus.wb_data  = 32'hDEAD;
        bus.rf_grant = 1'b1;
        #1;
        chk("popfull_reg", bus.rf_write_reg, 1);
        tick();
        bus.wb_valid = 1'b0;
        chk("popfull_blocked", bus.pending, 64'h1C);
        for (int i = 2; i <= 4; i++) begin
            chk("order_write", bus.rf_write, 1);
            chk("order_reg",   bus.rf_write_reg, 64'(i));
            chk("order_data",  bus.rf_write_data, 64'h100 + 64'(i));
            tick();
        end
        chk("order_empty", bus.empty, 1);

        // x0 request handshakes but is dropped
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd0;
        bus.wb_data  = 32'hFFFF;
        #1;
        chk("x0_ready", bus.wb_ready, 1);
        tick();
        bus.wb_valid = 1'b0;
        chk("x0_empty",   bus.empty, 1);
        chk("x0_pending", bus.pending, 0);
        chk("x0_write",   bus.rf_write, 0);

        // Push+pop at count 3, then flush
        bus.rf_grant = 1'b0;
        push(5'd7,  32'h70);
        push(5'd9,  32'h90);
        push(5'd11, 32'hB0);
        bus.rf_grant = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd12;
        bus.wb_data  = 32'hC0;
        #1;
        chk("pp_head", bus.rf_write_reg, 7);
        tick();
        bus.wb_valid = 1'b0;
        bus.rf_grant = 1'b0;
        chk("pp_pending", bus.pending, 64'h1A00);
        chk("pp_full",    bus.full, 0);
        chk("pp_head2",   bus.rf_write_data, 32'h90);
        bus.flush    = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd13;
        tick();
        bus.flush    = 1'b0;
        bus.wb_valid = 1'b0;
        bus.rf_grant = 1'b1;
        #1;
        chk("flush_empty",   bus.empty, 1);
        chk("flush_pending", bus.pending, 0);
        chk("flush_write",   bus.rf_write, 0);

        // Forwarding lookup and same-register ordering
        bus.rf_grant = 1'b0;
        push(5'd8, 32'h11);
        push(5'd8, 32'h22);
        push(5'd5, 32'h55);
        bus.read_reg1 = 5'd8;
        bus.read_reg2 = 5'd0;
        #1;
`ifdef WB_FORWARD_EN
        chk("fwd_hit1",   bus.fwd_hit1, 1);
        chk("fwd_data1",  bus.fwd_data1, 32'h22);
        chk("fwd_hit2x0", bus.fwd_hit2, 0);
        bus.read_reg2 = 5'd5;
        #1;
        chk("fwd_hit2",  bus.fwd_hit2, 1);
        chk("fwd_data2", bus.fwd_data2, 32'h55);
`else
        chk("nofwd_hit1",  bus.fwd_hit1, 0);
        chk("nofwd_data1", bus.fwd_data1, 0);
        chk("nofwd_hit2",  bus.fwd_hit2, 0);
`endif
        chk("same_pending", bus.pending, 64'h120);
        bus.rf_grant = 1'b1;
        #1;
        chk("same_first", bus.rf_write_data, 32'h11);
        tick();
        chk("same_second", bus.rf_write_data, 32'h22);
        chk("same_reg",    bus.rf_write_reg, 8);
        tick();
        chk("same_third",  bus.rf_write_reg, 5);
        tick();
        chk("same_empty",  bus.empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
